// File: rtl/hp_vpu_pkg.sv
// Hyperplane VPU shared types and defaults.
// rsp_entry_t is the payload carried by one response-reorder slot.
package hp_vpu_pkg;

  localparam int unsigned HP_VPU_ID_W   = 4;
  localparam int unsigned HP_VPU_DATA_W = 32;

  typedef struct packed {
    logic [HP_VPU_DATA_W-1:0] data;
    logic                     err;
    logic                     wb;
  } rsp_entry_t;

endpackage

// File: rtl/hp_vpu_rsp_rob.sv
// hp_vpu_rsp_rob: in-order response reorder buffer of the Hyperplane VPU.
// Hands out sequential IDs, collects out-of-order completions into a slot
// array and returns one response per ID, in allocation order, over a
// valid/ready handshake.
// Optional feature: define HP_VPU_RSP_BYPASS_EN to forward a completion for
// the head ID straight into the output register (1-cycle latency instead of 2).
module hp_vpu_rsp_rob
  import hp_vpu_pkg::*;
#(
  parameter int unsigned ID_W   = HP_VPU_ID_W,
  parameter int unsigned DATA_W = HP_VPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_i,
  output logic              alloc_ready_o,
  output logic [ID_W-1:0]   alloc_id_o,
  input  logic              cpl_valid_i,
  input  logic [ID_W-1:0]   cpl_id_i,
  input  logic [DATA_W-1:0] cpl_data_i,
  input  logic              cpl_err_i,
  input  logic              cpl_wb_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              rsp_wb_o,
  input  logic              flush_i,
  output logic [ID_W:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              proto_err_o
);

  localparam int unsigned DEPTH = 1 << ID_W;

  localparam logic [ID_W:0] PTR_ONE  = {{ID_W{1'b0}}, 1'b1};
  localparam logic [ID_W:0] FULL_CNT = {1'b1, {ID_W{1'b0}}};

  // Slot payload at this instance's data width (rsp_entry_t is the default-width form).
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic              wb;
  } slot_t;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [ID_W:0]    tail;
  logic [ID_W:0]    head;
  logic [ID_W:0]    rel;

  logic [DEPTH-1:0] done;
  slot_t            mem [DEPTH];

  logic [ID_W-1:0]  cpl_off;
  logic [ID_W:0]    pend;
  logic             cpl_legal;
  logic             load_ok;
  logic             byp;
  logic             load;
  logic             cpl_to_array;
  logic             alloc_fire;
  logic             rsp_fire;
  slot_t            load_entry;
  slot_t            cpl_entry;

  assign count_o       = tail - rel;
  assign full_o        = (count_o == FULL_CNT);
  assign empty_o       = (count_o == '0);
  assign alloc_ready_o = !full_o;
  assign alloc_id_o    = tail[ID_W-1:0];

  // Completion legality, output-load decision and optional head bypass.
  always_comb begin
    cpl_entry  = '{data: cpl_data_i, err: cpl_err_i, wb: cpl_wb_i};
    cpl_off    = cpl_id_i - head[ID_W-1:0];
    pend       = tail - head;
    // Legal IDs are allocated but not yet moved to the output, and not yet done.
    cpl_legal  = cpl_valid_i && ({1'b0, cpl_off} < pend) && !done[cpl_id_i];
    load_ok    = !rsp_valid_o || rsp_ready_i;
    byp        = 1'b0;
`ifdef HP_VPU_RSP_BYPASS_EN
    byp        = cpl_legal && (cpl_id_i == head[ID_W-1:0]) && load_ok;
`endif
    load         = !flush_i && load_ok && (done[head[ID_W-1:0]] || byp);
    cpl_to_array = !flush_i && cpl_legal && !byp;
    alloc_fire   = !flush_i && alloc_i && alloc_ready_o;
    rsp_fire     = !flush_i && rsp_valid_o && rsp_ready_i;
    load_entry   = byp ? cpl_entry : mem[head[ID_W-1:0]];
  end

  // Pointer update; flush collapses head and rel onto tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail <= '0;
      head <= '0;
      rel  <= '0;
    end else if (flush_i) begin
      head <= tail;
      rel  <= tail;
    end else begin
      if (alloc_fire) tail <= tail + PTR_ONE;
      if (load)       head <= head + PTR_ONE;
      if (rsp_fire)   rel  <= rel + PTR_ONE;
    end
  end

  // Done bits: cleared on allocation and on move to output, set by completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= '0;
    end else if (flush_i) begin
      done <= '0;
    end else begin
      if (alloc_fire)   done[tail[ID_W-1:0]] <= 1'b0;
      if (load)         done[head[ID_W-1:0]] <= 1'b0;
      if (cpl_to_array) done[cpl_id_i]       <= 1'b1;
    end
  end

  // Slot payload storage, written at the completing ID.
  always_ff @(posedge clk) begin
    if (cpl_to_array) mem[cpl_id_i] <= cpl_entry;
  end

  // Output register: loads from the head slot (or bypass), holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      rsp_wb_o    <= 1'b0;
    end else if (flush_i) begin
      rsp_valid_o <= 1'b0;
    end else if (load) begin
      rsp_valid_o <= 1'b1;
      rsp_id_o    <= head[ID_W-1:0];
      rsp_data_o  <= load_entry.data;
      rsp_err_o   <= load_entry.err;
      rsp_wb_o    <= load_entry.wb;
    end else if (rsp_fire) begin
      rsp_valid_o <= 1'b0;
    end
  end

  // Sticky protocol-error flag for dropped completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_o <= 1'b0;
    end else if (!flush_i && cpl_valid_i && !cpl_legal) begin
      proto_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hp_vpu_rsp_rob.sv
// Testbench for hp_vpu_rsp_rob: directed scenarios followed by random traffic,
// checked against a behavioural model built on allocation/acceptance counts.
module tb_hp_vpu_rsp_rob;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
`ifdef HP_VPU_RSP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_i;
  logic              alloc_ready_o;
  logic [ID_W-1:0]   alloc_id_o;
  logic              cpl_valid_i;
  logic [ID_W-1:0]   cpl_id_i;
  logic [DATA_W-1:0] cpl_data_i;
  logic              cpl_err_i;
  logic              cpl_wb_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [ID_W-1:0]   rsp_id_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              rsp_wb_o;
  logic              flush_i;
  logic [ID_W:0]     count_o;
  logic              full_o;
  logic              empty_o;
  logic              proto_err_o;

  hp_vpu_rsp_rob #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_i(alloc_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
    .cpl_valid_i(cpl_valid_i), .cpl_id_i(cpl_id_i), .cpl_data_i(cpl_data_i),
    .cpl_err_i(cpl_err_i), .cpl_wb_i(cpl_wb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .rsp_wb_o(rsp_wb_o),
    .flush_i(flush_i), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: total IDs allocated / responses accepted, plus per-ID
  // completion record for IDs that are outstanding.
  int unsigned     m_tail;
  int unsigned     m_rel;
  bit              m_done [DEPTH];
  logic [31:0]     m_data [DEPTH];
  bit              m_err  [DEPTH];
  bit              m_wb   [DEPTH];
  bit              m_perr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_tail = 0;
    m_rel  = 0;
    m_perr = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_i = 1'b0; cpl_valid_i = 1'b0; cpl_id_i = '0; cpl_data_i = '0;
    cpl_err_i = 1'b0; cpl_wb_i = 1'b0; rsp_ready_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rsp_valid_o), 0);
    chk("rst_count", 64'(count_o), 0);
    chk("rst_empty", 64'(empty_o), 1);
    chk("rst_full", 64'(full_o), 0);
    chk("rst_ready", 64'(alloc_ready_o), 1);
    chk("rst_alloc_id", 64'(alloc_id_o), 0);
    chk("rst_proto", 64'(proto_err_o), 0);
    chk("rst_rsp_fields", 64'({rsp_id_o, rsp_data_o, rsp_err_o, rsp_wb_o}), 0);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, check any handshake against the model, advance
  // the model by the rules, then check the visible bookkeeping outputs.
  task automatic step(input bit a, input bit cv, input int unsigned cid,
                      input logic [31:0] cd, input bit ce, input bit cw,
                      input bit rdy, input bit fl);
    bit          afire, hs, legal;
    int unsigned exp_id, off;
    alloc_i = a; cpl_valid_i = cv; cpl_id_i = 4'(cid); cpl_data_i = cd;
    cpl_err_i = ce; cpl_wb_i = cw; rsp_ready_i = rdy; flush_i = fl;
    afire  = a && ((m_tail - m_rel) < DEPTH);
    hs     = rsp_valid_o && rdy && !fl;
    exp_id = m_rel % DEPTH;
    if (afire) chk("alloc_id_grant", 64'(alloc_id_o), 64'(m_tail % DEPTH));
    if (hs) begin
      chk("rsp_id", 64'(rsp_id_o), 64'(exp_id));
      chk("rsp_completed", 64'(m_done[exp_id]), 1);
      chk("rsp_payload", 64'({rsp_data_o, rsp_err_o, rsp_wb_o}),
          64'({m_data[exp_id], m_err[exp_id], m_wb[exp_id]}));
    end
    off   = (cid + DEPTH - (m_rel % DEPTH)) % DEPTH;
    legal = cv && (off < (m_tail - m_rel)) && !m_done[cid];
    @(posedge clk);
    #1;
    if (fl) begin
      m_rel = m_tail;
      for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
    end else begin
      if (hs) begin
        m_done[exp_id] = 1'b0;
        m_rel++;
      end
      if (cv) begin
        if (legal) begin
          m_done[cid] = 1'b1; m_data[cid] = cd; m_err[cid] = ce; m_wb[cid] = cw;
        end else begin
          m_perr = 1'b1;
        end
      end
      if (afire) m_tail++;
    end
    chk("count", 64'(count_o), 64'(m_tail - m_rel));
    chk("empty", 64'(empty_o), 64'(m_tail == m_rel));
    chk("full", 64'(full_o), 64'((m_tail - m_rel) == DEPTH));
    chk("alloc_ready", 64'(alloc_ready_o), 64'((m_tail - m_rel) != DEPTH));
    chk("alloc_id", 64'(alloc_id_o), 64'(m_tail % DEPTH));
    chk("proto_err", 64'(proto_err_o), 64'(m_perr));
    if (fl) chk("flush_valid", 64'(rsp_valid_o), 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic cpl(input int unsigned id, input logic [31:0] d, input bit rdy);
    step(0, 1, id, d, d[0], d[1], rdy, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && m_rel != m_tail; n++) idle(1);
    chk("drain_left", 64'(m_tail - m_rel), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cand [$];
    int unsigned sel;
    do_reset();

    // A: allocate 0,1,2; complete out of order; responses return in order.
    repeat (3) step(1, 0, 0, 0, 0, 0, 1, 0);
    cpl(2, 32'hC, 1);
    cpl(0, 32'hA, 1);
    cpl(1, 32'hB, 1);
    drain();

    // B: completion-to-response latency with an empty output register.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    cpl(3, 32'h1234_5678, 0);
    chk("lat_n1", 64'(rsp_valid_o), 64'(BYP));
    idle(0);
    chk("lat_n2", 64'(rsp_valid_o), 1);
    idle(1);

    // C: host stall holds the presented response stable.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    cpl(0, 32'hDEAD_0000, 0);
    cpl(1, 32'hBEEF_0001, 0);
    for (int s = 0; s < 5; s++) begin
      idle(0);
      chk("stall_valid", 64'(rsp_valid_o), 1);
      chk("stall_id", 64'(rsp_id_o), 0);
      chk("stall_data", 64'(rsp_data_o), 64'(m_data[0]));
    end
    idle(1);
    chk("after_stall_valid", 64'(rsp_valid_o), 1);
    chk("after_stall_id", 64'(rsp_id_o), 1);
    drain();

    // D: fill to full, 17th alloc ignored, one accept frees ID 0.
    do_reset();
    repeat (16) step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("full_set", 64'(full_o), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("alloc_blocked_id", 64'(alloc_id_o), 0);
    cpl(0, 32'h0000_5A5A, 0);
    for (int n = 0; n < 8 && m_rel == 0; n++) idle(rsp_valid_o);
    chk("full_accept", 64'(m_rel), 1);
    chk("reopen_ready", 64'(alloc_ready_o), 1);
    chk("next_grant", 64'(alloc_id_o), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // E: flush with 4 allocated, 2 done, 1 in the output register.
    do_reset();
    repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0);
    cpl(0, 32'h11, 0);
    cpl(1, 32'h22, 0);
    cpl(2, 32'h33, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("flush_count", 64'(count_o), 0);
    chk("flush_empty", 64'(empty_o), 1);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("post_flush_id", 64'(alloc_id_o), 5);
    cpl(4, 32'h44, 1);
    drain();

    // F: illegal completions.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    cpl(0, 32'hAAAA, 0);
    chk("legal_no_err", 64'(proto_err_o), 0);
    cpl(0, 32'hBBBB, 0);
    chk("dup_err", 64'(proto_err_o), 1);
    cpl(5, 32'hCCCC, 0);
    repeat (3) idle(0);
    chk("err_sticky", 64'(proto_err_o), 1);
    cpl(1, 32'hDDDD, 1);
    drain();
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    cpl(5, 32'h5, 0);
    chk("oow_err", 64'(proto_err_o), 1);

    // G: random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cand.delete();
      for (int unsigned k = 0; k < m_tail - m_rel; k++)
        if (!m_done[(m_rel + k) % DEPTH]) cand.push_back((m_rel + k) % DEPTH);
      if ($urandom_range(0, 199) == 0) begin
        step($urandom_range(0, 1), 0, 0, 0, 0, 0, $urandom_range(0, 1), 1);
      end else if ($urandom_range(0, 59) == 0) begin
        step($urandom_range(0, 1), 1, $urandom_range(0, 15), $urandom, 0, 0,
             $urandom_range(0, 3) != 0, 0);
      end else if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
        sel = cand[$urandom_range(0, cand.size() - 1)];
        step($urandom_range(0, 1), 1, sel, $urandom, $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3) != 0, 0);
      end else begin
        step($urandom_range(0, 1), 0, 0, 0, 0, 0, $urandom_range(0, 3) != 0, 0);
      end
    end
    for (int n = 0; n < 200 && m_rel != m_tail; n++) begin
      cand.delete();
      for (int unsigned k = 0; k < m_tail - m_rel; k++)
        if (!m_done[(m_rel + k) % DEPTH]) cand.push_back((m_rel + k) % DEPTH);
      if (cand.size() > 0) cpl(cand[0], $urandom, 1);
      else idle(1);
    end
    chk("rand_drain_left", 64'(m_tail - m_rel), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
